// File: rtl/ssp_frame_tx_pkg.sv
// Shared definitions for the FPGA->ARM SSP transmitter: FSM encodings and default
// geometry, kept identical to the values used by the ARM-side SSP receive logic.
package ssp_frame_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ssp_state_e;

  localparam int SSP_DATA_W     = 8;
  localparam int SSP_CLK_DIV    = 8;
  localparam int SSP_FIFO_DEPTH = 4;

endpackage

// File: rtl/ssp_tx_fifo.sv
// Synchronous FIFO buffering words between a mode core and the SSP serialiser.
// DEPTH must be a power of two so the pointers wrap naturally.
module ssp_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage is not reset; the count alone defines which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ssp_frame_tx.sv
// Serialises buffered words MSB-first onto the ARM SSP link (ssp_clk/ssp_frame/ssp_din).
// Holds the bit-clock divider, the frame FSM, the shift register and the bit counter.
module ssp_frame_tx import ssp_frame_tx_pkg::*; #(
  parameter int DATA_W     = SSP_DATA_W,
  parameter int CLK_DIV    = SSP_CLK_DIV,
  parameter int FIFO_DEPTH = SSP_FIFO_DEPTH
) (
  input  logic              ck_1356meg,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              ssp_clk,
  output logic              ssp_frame,
  output logic              ssp_din,
  output ssp_state_e        dbg_state
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ssp_state_e        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              clk_q, clk_d;
  logic              frame_q, frame_d;
  logic              din_q, din_d;
  logic              busy_q, busy_d;

  logic              running, tick, start, push, pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;

  // Handshake: a word transfers on any cycle with tx_valid & tx_ready; tx_ready is
  // low while full or in reset, and the producer may change tx_data freely otherwise.
  assign tx_ready = !fifo_full && !reset;
  assign push     = tx_valid && tx_ready;

  // Running keeps the divider alive until an in-flight word has fully left.
  assign running = enable || (state_q == SHIFT);
  assign tick    = running && (div_q == DIV_LAST);
  assign start   = tick && enable && !fifo_empty &&
                   ((state_q == IDLE) || (bit_q == BIT_LAST));
  assign pop     = start;

  ssp_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (ck_1356meg),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (tx_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    frame_d = frame_q;
    din_d   = din_q;
    div_d   = '0;
    if (running) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

    if (tick) begin
      if (start) begin
        state_d = SHIFT;
        shreg_d = fifo_rdata;
        bit_d   = '0;
        frame_d = 1'b1;
        din_d   = fifo_rdata[DATA_W-1];
      end else if ((state_q == SHIFT) && (bit_q != BIT_LAST)) begin
        bit_d   = bit_q + 1'b1;
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        din_d   = shreg_q[DATA_W-2];
        frame_d = 1'b0;
      end else begin
        state_d = IDLE;
        frame_d = 1'b0;
        din_d   = 1'b0;
      end
    end

    // Registered copies of next-state values keep every output glitch-free.
    clk_d  = (div_d >= DIV_HALF);
    busy_d = (state_d == SHIFT) || push || (fifo_count > CNT_ONE) ||
             ((fifo_count == CNT_ONE) && !pop);
  end

  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      clk_q   <= 1'b0;
      frame_q <= 1'b0;
      din_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      clk_q   <= clk_d;
      frame_q <= frame_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
    end
  end

  assign ssp_clk   = clk_q;
  assign ssp_frame = frame_q;
  assign ssp_din   = din_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ssp_frame_tx.sv
// Directed bench for ssp_frame_tx: default instance (CLK_DIV=8) plus a CLK_DIV=2 instance,
// with an SSP receiver model assembling bytes on ssp_clk rising edges.
module tb_ssp_frame_tx;
  import ssp_frame_tx_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic       en_a = 1'b0, txv_a = 1'b0;
  logic [7:0] txd_a = 8'h00;
  logic       rdy_a, busy_a, sclk_a, frame_a, din_a;
  ssp_state_e st_a;

  // Instance B: CLK_DIV = 2
  logic       en_b = 1'b0, txv_b = 1'b0;
  logic [7:0] txd_b = 8'h00;
  logic       rdy_b, busy_b, sclk_b, frame_b, din_b;
  ssp_state_e st_b;

  ssp_frame_tx dut_a (
    .ck_1356meg (clk), .reset (reset), .enable (en_a),
    .tx_data (txd_a), .tx_valid (txv_a), .tx_ready (rdy_a), .busy (busy_a),
    .ssp_clk (sclk_a), .ssp_frame (frame_a), .ssp_din (din_a), .dbg_state (st_a)
  );

  ssp_frame_tx #(.CLK_DIV (2)) dut_b (
    .ck_1356meg (clk), .reset (reset), .enable (en_b),
    .tx_data (txd_b), .tx_valid (txv_b), .tx_ready (rdy_b), .busy (busy_b),
    .ssp_clk (sclk_b), .ssp_frame (frame_b), .ssp_din (din_b), .dbg_state (st_b)
  );

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         gap_q[$];
  int         cyc = 0, last_start = -1, frame_run = 0, frame_len = 0, rx_bits = 0;
  logic       prev_clk = 1'b0, prev_frame = 1'b0;
  logic [7:0] rx_sh = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push_a(input logic [7:0] d);
    txv_a = 1'b1;
    txd_a = d;
    @(negedge clk);
    txv_a = 1'b0;
  endtask

  // Receiver model for instance A: samples on ssp_clk rising, frame marks the MSB.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        rx_bits = 0; prev_clk = 1'b0; prev_frame = 1'b0; frame_run = 0;
      end else begin
        if (frame_a && !prev_frame) begin
          if (last_start >= 0) gap_q.push_back(cyc - last_start);
          last_start = cyc;
        end
        if (frame_a) frame_run++;
        else if (prev_frame) begin frame_len = frame_run; frame_run = 0; end
        if (sclk_a && !prev_clk) begin
          if (frame_a) begin rx_sh = {7'd0, din_a}; rx_bits = 1; end
          else if (rx_bits != 0) begin rx_sh = {rx_sh[6:0], din_a}; rx_bits++; end
          if (rx_bits == 8) begin rx_q.push_back(rx_sh); rx_bits = 0; end
        end
        prev_clk = sclk_a;
        prev_frame = frame_a;
      end
    end
  end

  initial begin
    int rejects;
    int nchk;
    int tog_err;
    logic [7:0] bits_b;
    logic busy15, busy16;

    // ---- 0: reset state
    repeat (3) @(negedge clk);
    chk("rst_ssp_clk", sclk_a, 0);
    chk("rst_frame", frame_a, 0);
    chk("rst_din", din_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ready_low", rdy_a, 0);
    chk("rst_state", st_a, IDLE);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", rdy_a, 1);

    // ---- 1: single word 0xA5
    en_a = 1'b1;
    push_a(8'hA5);
    chk("t1_busy", busy_a, 1);
    for (int i = 0; i < 200 && rx_q.size() == 0; i++) @(negedge clk);
    chk("t1_rx_timeout", rx_q.size() != 0, 1);
    if (rx_q.size() != 0) chk("t1_word", rx_q.pop_front(), 8'hA5);
    for (int i = 0; i < 40 && busy_a !== 1'b0; i++) @(negedge clk);
    chk("t1_idle_timeout", busy_a, 0);
    chk("t1_frame_len", frame_len, 8);
    chk("t1_frame_after", frame_a, 0);
    chk("t1_din_after", din_a, 0);

    // ---- 2: four back-to-back words, pushed right after a tick
    gap_q.delete();
    last_start = -1;
    for (int i = 0; i < 40 && sclk_a !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 40 && sclk_a !== 1'b0; i++) @(negedge clk);
    push_a(8'h01); push_a(8'h80); push_a(8'hFF); push_a(8'h00);
    chk("t2_ready_full", rdy_a, 0);
    chk("t2_busy", busy_a, 1);
    for (int i = 0; i < 400 && rx_q.size() < 4; i++) @(negedge clk);
    chk("t2_rx_count", rx_q.size(), 4);
    exp_q = '{8'h01, 8'h80, 8'hFF, 8'h00};
    while (rx_q.size() != 0 && exp_q.size() != 0) chk("t2_word", rx_q.pop_front(), exp_q.pop_front());
    chk("t2_gap_count", gap_q.size(), 3);
    while (gap_q.size() != 0) chk("t2_gap", gap_q.pop_front(), 64);
    for (int i = 0; i < 40 && busy_a !== 1'b0; i++) @(negedge clk);
    chk("t2_idle", busy_a, 0);
    rx_q.delete();

    // ---- 3: enable drops mid-word; second word stays queued
    push_a(8'hC3);
    push_a(8'h3C);
    for (int i = 0; i < 100 && rx_bits != 3; i++) @(negedge clk);
    chk("t3_bit2_timeout", rx_bits, 3);
    en_a = 1'b0;
    for (int i = 0; i < 100 && rx_q.size() == 0; i++) @(negedge clk);
    chk("t3_rx_timeout", rx_q.size() != 0, 1);
    if (rx_q.size() != 0) chk("t3_word", rx_q.pop_front(), 8'hC3);
    for (int i = 0; i < 20 && st_a !== IDLE; i++) @(negedge clk);
    chk("t3_state_idle", st_a, IDLE);
    nchk = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (sclk_a !== 1'b0) nchk++;
    end
    chk("t3_sclk_held_low", nchk, 0);
    chk("t3_busy_queued", busy_a, 1);
    chk("t3_ready", rdy_a, 1);
    chk("t3_frame", frame_a, 0);
    en_a = 1'b1;
    for (int i = 0; i < 200 && rx_q.size() == 0; i++) @(negedge clk);
    chk("t3_rx2_timeout", rx_q.size() != 0, 1);
    if (rx_q.size() != 0) chk("t3_word2", rx_q.pop_front(), 8'h3C);
    for (int i = 0; i < 40 && busy_a !== 1'b0; i++) @(negedge clk);
    chk("t3_idle", busy_a, 0);

    // ---- 4: reset during bit 4 of 0x5A
    push_a(8'h5A);
    for (int i = 0; i < 150 && rx_bits != 5; i++) @(negedge clk);
    chk("t4_bit4_timeout", rx_bits, 5);
    reset = 1'b1;
    @(negedge clk);
    chk("t4_sclk", sclk_a, 0);
    chk("t4_frame", frame_a, 0);
    chk("t4_din", din_a, 0);
    chk("t4_busy", busy_a, 0);
    chk("t4_ready_in_reset", rdy_a, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("t4_ready_after", rdy_a, 1);
    repeat (150) @(negedge clk);
    chk("t4_no_resume", rx_q.size(), 0);
    chk("t4_fifo_lost", busy_a, 0);

    // ---- 5: valid held high with changing data against a full FIFO
    exp_q.delete();
    rejects = 0;
    for (int i = 0; i < 200; i++) begin
      txv_a = 1'b1;
      txd_a = 8'(i + 16);
      if (rdy_a) exp_q.push_back(txd_a);
      else rejects++;
      @(negedge clk);
    end
    txv_a = 1'b0;
    chk("t5_backpressure", rejects > 0, 1);
    for (int i = 0; i < 800 && busy_a !== 1'b0; i++) @(negedge clk);
    chk("t5_drain", busy_a, 0);
    chk("t5_stream_len", rx_q.size(), exp_q.size());
    while (rx_q.size() != 0 && exp_q.size() != 0) chk("t5_stream", rx_q.pop_front(), exp_q.pop_front());

    // ---- 6: CLK_DIV=2 instance, one word in 16 cycles
    en_b = 1'b1;
    txv_b = 1'b1;
    txd_b = 8'h96;
    @(negedge clk);
    txv_b = 1'b0;
    for (int i = 0; i < 20 && frame_b !== 1'b1; i++) @(negedge clk);
    chk("t6_frame_timeout", frame_b, 1);
    chk("t6_sclk_start", sclk_b, 0);
    tog_err = 0;
    bits_b = 8'h00;
    busy15 = 1'b0;
    busy16 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (sclk_b !== k[0]) tog_err++;
      if (sclk_b === 1'b1) bits_b = {bits_b[6:0], din_b};
      if (k == 15) busy15 = busy_b;
      if (k == 16) busy16 = busy_b;
    end
    chk("t6_toggle", tog_err, 0);
    chk("t6_word", bits_b, 8'h96);
    chk("t6_busy_c15", busy15, 1);
    chk("t6_busy_c16", busy16, 0);
    chk("t6_state", st_b, IDLE);
    chk("t6_ready", rdy_b, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
